// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with CPU register window and level interrupt
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    input  logic        sys_select,
    input  logic        sys_rd,
    input  logic [3:0]  sys_we,
    input  logic [1:0]  sys_addr,
    input  logic [31:0] sys_wdata,
    output logic [31:0] sys_rdata,
    output logic        interrupt
);

    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  ACK      = 1'b1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [0:0]    state;
    logic          overrun;
    logic          int_enable;
    logic [8:0]    threshold;

    logic          ctl_wr;
    logic          thr_wr;
    logic          flush;
    logic          ovr_clr;
    logic          full;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          store;
    logic          lost;
    logic [7:0]    head_byte;
    logic [8:0]    count9;
    logic [8:0]    eff_thr;
    logic          unused_bits;

    assign unused_bits = &{1'b0, sys_wdata[31:9], sys_we[3:1]};

    assign ctl_wr    = sys_select & sys_we[0] & (sys_addr == 2'd2);
    assign thr_wr    = sys_select & sys_we[0] & (sys_addr == 2'd3);
    assign flush     = ctl_wr & sys_wdata[0];
    assign ovr_clr   = ctl_wr & sys_wdata[1];

    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);

    // rx_ack doubles as the push strobe; it is held low while reset is asserted
    // so an in-flight byte is neither acknowledged nor stored.
    assign rx_ack    = ~reset & (state == IDLE) & rx_valid & ~flush;
    assign push      = rx_ack;
    assign pop       = sys_select & sys_rd & (sys_addr == 2'd0) & not_empty & ~flush;

    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign store     = push & (~full | pop);
    assign lost      = push & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (push) begin
                state <= ACK;
            end
        end else begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun    <= 1'b0;
            int_enable <= 1'b0;
            threshold  <= 9'd1;
        end else begin
            if (lost) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (ctl_wr) begin
                int_enable <= sys_wdata[2];
            end
            if (thr_wr) begin
                threshold <= sys_wdata[8:0];
            end
        end
    end

    assign head_byte = not_empty ? mem[rd_ptr] : 8'h00;
    assign count9    = 9'(count);
    assign eff_thr   = (threshold == 9'd0) ? 9'd1 : threshold;
    assign interrupt = int_enable & ((count9 >= eff_thr) | overrun);

    always_comb begin
        sys_rdata = 32'h0;
        if (sys_select) begin
            case (sys_addr)
                2'd0:    sys_rdata = {23'b0, not_empty, head_byte};
                2'd1:    sys_rdata = {19'b0, count9, int_enable, overrun, full, not_empty};
                2'd2:    sys_rdata = 32'h0;
                default: sys_rdata = {23'b0, threshold};
            endcase
        end
    end

endmodule
